// File: rtl/pipe_reg_fd_de.sv
// ---------------------------------------------------------------------------
// pipe_reg_fd_de
// Front-end pipeline register bank of the 5-stage MIPS core: PC register,
// IF/ID register and ID/EX register. Applies the hazard unit's stall, flush
// and redirect controls as per-stage hold / load / bubble actions. A valid
// bit travels with each instruction.
//
// Optional feature (macro PERF_CNT_EN):
//   defined   - saturating StallCnt / BubbleCnt counters with sync PerfClr
//   undefined - no counter flops; StallCnt = BubbleCnt = 0, PerfClr ignored
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   StallF, StallD           hold PC register / IF/ID register
//   FlushE                   bubble into ID/EX register
//   PCSrcD                   taken redirect resolved in decode; squash IF/ID
//   PCNextF -> PCF           PC register
//   InstrF, PCPlus4F         fetch-side inputs of IF/ID
//   InstrD, PCPlus4D, ValidD IF/ID outputs
//   CtrlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD   decode-side inputs of ID/EX
//   CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE   ID/EX outputs
//   PerfClr                  synchronous clear of the counters
//   StallCnt, BubbleCnt      performance counters
// ---------------------------------------------------------------------------
module pipe_reg_fd_de #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    RF_ADDR_WIDTH = 5,
  parameter int                    CTRL_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0,
  parameter int                    CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushE,
  input  logic                     PCSrcD,
  input  logic [DATA_WIDTH-1:0]    PCNextF,
  output logic [DATA_WIDTH-1:0]    PCF,
  input  logic [DATA_WIDTH-1:0]    InstrF,
  input  logic [DATA_WIDTH-1:0]    PCPlus4F,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [DATA_WIDTH-1:0]    PCPlus4D,
  output logic                     ValidD,
  input  logic [CTRL_WIDTH-1:0]    CtrlD,
  input  logic [DATA_WIDTH-1:0]    RD1D,
  input  logic [DATA_WIDTH-1:0]    RD2D,
  input  logic [DATA_WIDTH-1:0]    SignImmD,
  input  logic [RF_ADDR_WIDTH-1:0] RsD,
  input  logic [RF_ADDR_WIDTH-1:0] RtD,
  input  logic [RF_ADDR_WIDTH-1:0] RdD,
  output logic [CTRL_WIDTH-1:0]    CtrlE,
  output logic [DATA_WIDTH-1:0]    RD1E,
  output logic [DATA_WIDTH-1:0]    RD2E,
  output logic [DATA_WIDTH-1:0]    SignImmE,
  output logic [RF_ADDR_WIDTH-1:0] RsE,
  output logic [RF_ADDR_WIDTH-1:0] RtE,
  output logic [RF_ADDR_WIDTH-1:0] RdE,
  output logic                     ValidE,
  input  logic                     PerfClr,
  output logic [CNT_WIDTH-1:0]     StallCnt,
  output logic [CNT_WIDTH-1:0]     BubbleCnt
);

  // PC register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          PCF <= RESET_PC;
    else if (!StallF) PCF <= PCNextF;
  end

  // IF/ID register: stall beats squash, because a stalled branch re-resolves
  // next cycle and must not kill the instruction it is waiting on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (PCSrcD) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= InstrF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  // ID/EX register: never stalled; a flush loads an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      CtrlE    <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      SignImmE <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
      ValidE   <= 1'b0;
    end else begin
      CtrlE    <= CtrlD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      SignImmE <= SignImmD;
      RsE      <= RsD;
      RtE      <= RtD;
      RdE      <= RdD;
      ValidE   <= ValidD;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_q;
  logic                 bubble_evt;

  // A squash and a flush in the same cycle still count as one bubble cycle.
  assign bubble_evt = FlushE | (PCSrcD & ~StallD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst || PerfClr) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (StallD && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (bubble_evt && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`else
  logic unused_perf_clr;

  assign unused_perf_clr = PerfClr;
  assign StallCnt        = '0;
  assign BubbleCnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_fd_de.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_fd_de
// Self-checking bench for pipe_reg_fd_de. A behavioural model of the three
// stages (plain variables updated from the stage rules) predicts every
// output; directed scenarios additionally use hand-derived constants.
// Counter expectations follow PERF_CNT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pipe_reg_fd_de;
  localparam int          DW   = 32;
  localparam int          AW   = 5;
  localparam int          CTW  = 8;
  localparam int          CNTW = 8;
  localparam logic [31:0] RPC  = 32'h0;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic StallF, StallD, FlushE, PCSrcD, PerfClr;
  logic [DW-1:0]  PCNextF, PCF, InstrF, PCPlus4F, InstrD, PCPlus4D;
  logic           ValidD, ValidE;
  logic [CTW-1:0] CtrlD, CtrlE;
  logic [DW-1:0]  RD1D, RD2D, SignImmD, RD1E, RD2E, SignImmE;
  logic [AW-1:0]  RsD, RtD, RdD, RsE, RtE, RdE;
  logic [CNTW-1:0] StallCnt, BubbleCnt;

  pipe_reg_fd_de #(
    .DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .CTRL_WIDTH(CTW),
    .RESET_PC(RPC), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCNextF(PCNextF), .PCF(PCF), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E),
    .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE), .ValidE(ValidE),
    .PerfClr(PerfClr), .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [DW-1:0]  m_pc, m_instr_d, m_pc4_d;
  logic           m_valid_d, m_valid_e;
  logic [CTW-1:0] m_ctrl_e;
  logic [DW-1:0]  m_rd1_e, m_rd2_e, m_imm_e;
  logic [AW-1:0]  m_rs_e, m_rt_e, m_rd_e;
  int             m_stall_cnt, m_bubble_cnt;

  function automatic void model_reset();
    m_pc = RPC; m_instr_d = '0; m_pc4_d = '0; m_valid_d = 1'b0;
    m_ctrl_e = '0; m_rd1_e = '0; m_rd2_e = '0; m_imm_e = '0;
    m_rs_e = '0; m_rt_e = '0; m_rd_e = '0; m_valid_e = 1'b0;
    m_stall_cnt = 0; m_bubble_cnt = 0;
  endfunction

  function automatic int expect_cnt(int v);
`ifdef PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // One clock: the model consumes the inputs that were stable at the edge.
  task automatic step();
    @(posedge clk);
    if (PerfClr) begin
      m_stall_cnt = 0; m_bubble_cnt = 0;
    end else begin
      if (StallD) m_stall_cnt = (m_stall_cnt < CMAX) ? m_stall_cnt + 1 : CMAX;
      if (FlushE || (PCSrcD && !StallD))
        m_bubble_cnt = (m_bubble_cnt < CMAX) ? m_bubble_cnt + 1 : CMAX;
    end
    if (FlushE) begin
      m_ctrl_e = '0; m_rd1_e = '0; m_rd2_e = '0; m_imm_e = '0;
      m_rs_e = '0; m_rt_e = '0; m_rd_e = '0; m_valid_e = 1'b0;
    end else begin
      m_ctrl_e = CtrlD; m_rd1_e = RD1D; m_rd2_e = RD2D; m_imm_e = SignImmD;
      m_rs_e = RsD; m_rt_e = RtD; m_rd_e = RdD; m_valid_e = m_valid_d;
    end
    if (!StallD) begin
      if (PCSrcD) begin
        m_instr_d = '0; m_pc4_d = '0; m_valid_d = 1'b0;
      end else begin
        m_instr_d = InstrF; m_pc4_d = PCPlus4F; m_valid_d = 1'b1;
      end
    end
    if (!StallF) m_pc = PCNextF;
    #1;
  endtask

  // Decode-side inputs derived from the instruction currently in D.
  task automatic drive_decode();
    CtrlD    = m_instr_d[31:24] ^ 8'h5A;
    RD1D     = m_instr_d ^ 32'h1111_1111;
    RD2D     = m_instr_d + 32'h100;
    SignImmD = {{16{m_instr_d[15]}}, m_instr_d[15:0]};
    RsD      = m_instr_d[25:21];
    RtD      = m_instr_d[20:16];
    RdD      = m_instr_d[15:11];
  endtask

  // Plain sequential fetch of one instruction.
  task automatic drive_fetch(input logic [DW-1:0] instr);
    StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0; PCSrcD = 1'b0; PerfClr = 1'b0;
    PCNextF  = m_pc + 32'd4;
    PCPlus4F = m_pc + 32'd4;
    InstrF   = instr;
    drive_decode();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 0; PerfClr = 0;
    PCNextF = 32'h1234; InstrF = 32'hFFFF_FFFF; PCPlus4F = 32'h1238;
    CtrlD = '1; RD1D = '1; RD2D = '1; SignImmD = '1; RsD = '1; RtD = '1; RdD = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({PCF, InstrD, PCPlus4D, ValidD} !== {RPC, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_fd: got pc=%h instr=%h pc4=%h vd=%b, want pc=%h rest 0",
               PCF, InstrD, PCPlus4D, ValidD, RPC);
    else n_pass++;
    n_checks++;
    if ({CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE} !== '0)
      $display("FAIL reset_e: got ctrl=%h rd1=%h rs=%h ve=%b, want all 0",
               CtrlE, RD1E, RsE, ValidE);
    else n_pass++;
    n_checks++;
    if ({StallCnt, BubbleCnt} !== '0)
      $display("FAIL reset_cnt: got stall=%0d bubble=%0d, want 0 0", StallCnt, BubbleCnt);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    logic [DW-1:0] prog [3];
    prog[0] = 32'h8C01_0004; prog[1] = 32'h0022_1820; prog[2] = 32'hAC03_0008;
    for (int i = 0; i < 3; i++) begin
      drive_fetch(prog[i]);
      step();
      n_checks++;
      if ({PCF, InstrD, PCPlus4D, ValidD} !== {32'(4 * (i + 1)), prog[i], 32'(4 * (i + 1)), 1'b1})
        $display("FAIL seq_d[%0d]: got pc=%h instr=%h pc4=%h vd=%b, want pc=%h instr=%h vd=1",
                 i, PCF, InstrD, PCPlus4D, ValidD, 32'(4 * (i + 1)), prog[i]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if ({RsE, RtE, RdE, ValidE} !== {prog[i-1][25:21], prog[i-1][20:16], prog[i-1][15:11], 1'b1})
          $display("FAIL seq_e[%0d]: got rs=%0d rt=%0d rd=%0d ve=%b, want rs=%0d rt=%0d rd=%0d ve=1",
                   i, RsE, RtE, RdE, ValidE, prog[i-1][25:21], prog[i-1][20:16], prog[i-1][15:11]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load_use();
    logic [DW-1:0] pc_hold;
    int            b0;
    drive_fetch(32'h0022_1820);
    step();
    pc_hold = PCF;
    b0 = m_bubble_cnt;
    drive_fetch(32'hDEAD_BEEF);
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    step();
    n_checks++;
    if ({PCF, InstrD, ValidD} !== {pc_hold, 32'h0022_1820, 1'b1})
      $display("FAIL loaduse_hold: got pc=%h instr=%h vd=%b, want pc=%h instr=00221820 vd=1",
               PCF, InstrD, ValidD, pc_hold);
    else n_pass++;
    n_checks++;
    if ({CtrlE, RsE, RtE, RdE, RD1E, ValidE} !== '0)
      $display("FAIL loaduse_bubble: got ctrl=%h rs=%0d rd1=%h ve=%b, want all 0",
               CtrlE, RsE, RD1E, ValidE);
    else n_pass++;
    n_checks++;
    if (BubbleCnt !== CNTW'(expect_cnt(b0 + 1)))
      $display("FAIL loaduse_bcnt: got %0d want %0d", BubbleCnt, expect_cnt(b0 + 1));
    else n_pass++;
    drive_fetch(32'h0000_0000);
    step();
    n_checks++;
    if ({RsE, RtE, RdE, ValidE, CtrlE} !== {5'd1, 5'd2, 5'd3, 1'b1, 8'h00 ^ 8'h5A})
      $display("FAIL loaduse_release: got rs=%0d rt=%0d rd=%0d ve=%b ctrl=%h, want 1 2 3 1 5a",
               RsE, RtE, RdE, ValidE, CtrlE);
    else n_pass++;
  endtask

  task automatic test_branch();
    int b0;
    drive_fetch(32'h1000_0003);
    step();
    b0 = m_bubble_cnt;
    drive_fetch(32'h2222_2222);
    PCSrcD = 1'b1;
    step();
    n_checks++;
    if ({InstrD, PCPlus4D, ValidD} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL branch_squash: got instr=%h pc4=%h vd=%b, want 0 0 0",
               InstrD, PCPlus4D, ValidD);
    else n_pass++;
    n_checks++;
    if (BubbleCnt !== CNTW'(expect_cnt(b0 + 1)))
      $display("FAIL branch_bcnt: got %0d want %0d", BubbleCnt, expect_cnt(b0 + 1));
    else n_pass++;
  endtask

  task automatic test_branch_stall();
    int s0, b0;
    drive_fetch(32'h1443_FFFD);
    step();
    s0 = m_stall_cnt; b0 = m_bubble_cnt;
    drive_fetch(32'h3333_3333);
    StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b1;
    step();
    n_checks++;
    if ({InstrD, ValidD, ValidE} !== {32'h1443_FFFD, 1'b1, 1'b1})
      $display("FAIL brstall_hold: got instr=%h vd=%b ve=%b, want 1443fffd 1 1",
               InstrD, ValidD, ValidE);
    else n_pass++;
    n_checks++;
    if ({StallCnt, BubbleCnt} !== {CNTW'(expect_cnt(s0 + 1)), CNTW'(expect_cnt(b0))})
      $display("FAIL brstall_cnt: got stall=%0d bubble=%0d, want %0d %0d",
               StallCnt, BubbleCnt, expect_cnt(s0 + 1), expect_cnt(b0));
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      StallD  = ($urandom_range(0, 3) == 0);
      StallF  = ($urandom_range(0, 7) == 0) ? ~StallD : StallD;
      FlushE  = ($urandom_range(0, 3) == 0);
      PCSrcD  = ($urandom_range(0, 4) == 0);
      PerfClr = ($urandom_range(0, 40) == 0);
      PCNextF = $urandom; InstrF = $urandom; PCPlus4F = $urandom;
      CtrlD = CTW'($urandom); RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
      RsD = AW'($urandom); RtD = AW'($urandom); RdD = AW'($urandom);
      step();
      n_checks++;
      if ({PCF, InstrD, PCPlus4D, ValidD} !== {m_pc, m_instr_d, m_pc4_d, m_valid_d}) begin
        if (errs < 5)
          $display("FAIL rand_fd[%0d]: got pc=%h instr=%h pc4=%h vd=%b, want pc=%h instr=%h pc4=%h vd=%b",
                   i, PCF, InstrD, PCPlus4D, ValidD, m_pc, m_instr_d, m_pc4_d, m_valid_d);
        errs++;
      end else n_pass++;
      n_checks++;
      if ({CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE} !==
          {m_ctrl_e, m_rd1_e, m_rd2_e, m_imm_e, m_rs_e, m_rt_e, m_rd_e, m_valid_e}) begin
        if (errs < 5)
          $display("FAIL rand_e[%0d]: got ctrl=%h rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d ve=%b, want ctrl=%h rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d ve=%b",
                   i, CtrlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE,
                   m_ctrl_e, m_rd1_e, m_rd2_e, m_imm_e, m_rs_e, m_rt_e, m_rd_e, m_valid_e);
        errs++;
      end else n_pass++;
      n_checks++;
      if ({StallCnt, BubbleCnt} !== {CNTW'(expect_cnt(m_stall_cnt)), CNTW'(expect_cnt(m_bubble_cnt))}) begin
        if (errs < 5)
          $display("FAIL rand_cnt[%0d]: got stall=%0d bubble=%0d, want %0d %0d",
                   i, StallCnt, BubbleCnt, expect_cnt(m_stall_cnt), expect_cnt(m_bubble_cnt));
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_counters();
    drive_fetch(32'h0);
    PerfClr = 1'b1;
    step();
    PerfClr = 1'b0; StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    for (int i = 0; i < CMAX + 4; i++) step();
    n_checks++;
    if ({StallCnt, BubbleCnt} !== {CNTW'(expect_cnt(CMAX)), CNTW'(expect_cnt(CMAX))})
      $display("FAIL cnt_saturate: got stall=%0d bubble=%0d, want %0d %0d",
               StallCnt, BubbleCnt, expect_cnt(CMAX), expect_cnt(CMAX));
    else n_pass++;
    // Clear wins over a simultaneous increment.
    PerfClr = 1'b1;
    step();
    n_checks++;
    if ({StallCnt, BubbleCnt} !== '0)
      $display("FAIL cnt_clear: got stall=%0d bubble=%0d, want 0 0", StallCnt, BubbleCnt);
    else n_pass++;
    PerfClr = 1'b0;
    step();
    n_checks++;
    if ({StallCnt, BubbleCnt} !== {CNTW'(expect_cnt(1)), CNTW'(expect_cnt(1))})
      $display("FAIL cnt_restart: got stall=%0d bubble=%0d, want %0d %0d",
               StallCnt, BubbleCnt, expect_cnt(1), expect_cnt(1));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive_fetch(32'h0000_0020);
    step();
    drive_fetch(32'h0000_0040);
    PCNextF = 32'h0000_0040;
    step();
    n_checks++;
    if ({PCF, ValidD, ValidE} !== {32'h40, 1'b1, 1'b1})
      $display("FAIL arst_pre: got pc=%h vd=%b ve=%b, want 40 1 1", PCF, ValidD, ValidE);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({PCF, ValidD, ValidE, InstrD} !== {RPC, 1'b0, 1'b0, 32'h0})
      $display("FAIL arst_now: got pc=%h vd=%b ve=%b instr=%h, want pc=%h vd=0 ve=0 instr=0",
               PCF, ValidD, ValidE, InstrD, RPC);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_fetch(32'h8C01_0004);
    step();
    n_checks++;
    if ({PCF, InstrD, ValidD, ValidE} !== {RPC + 32'd4, 32'h8C01_0004, 1'b1, 1'b0})
      $display("FAIL arst_resume: got pc=%h instr=%h vd=%b ve=%b, want %h 8c010004 1 0",
               PCF, InstrD, ValidD, ValidE, RPC + 32'd4);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_load_use();
    test_branch();
    test_branch_stall();
    test_random();
    test_counters();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
